// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO control stage and its RAM wrapper.
// Holds the RAM command encoding and the default geometry.
package fifo_pkg;
    localparam logic [1:0] RW_IDLE = 2'b00;
    localparam logic [1:0] RW_WR   = 2'b01;
    localparam logic [1:0] RW_RD   = 2'b10;
    localparam logic [1:0] RW_RW   = 2'b11;

    localparam int AW_DEF = 3;
    localparam int DW_DEF = 4;
endpackage

// File: rtl/fifo_ptr.sv
// AW-bit wrapping pointer with async active-low clear and increment enable.
module fifo_ptr #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);
    logic [AW-1:0] ptr_q, ptr_d;

    // Natural modulo-2**AW wrap, no end-of-range special case.
    assign ptr_d = ptr_q + {{(AW-1){1'b0}}, inc_i};
    assign ptr_o = ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage in front of a registered-read dual-address RAM:
// pointers, occupancy, flags, sticky errors and read-valid timing.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int AF_TH = 6,
    parameter int AE_TH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] addrw,
    output logic [AW-1:0] addrr,
    output logic [1:0]    rw,
    output logic          valid_out,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow_err,
    output logic          underflow_err
);
    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
    localparam logic [AW:0] AF_V  = (AW+1)'(AF_TH);
    localparam logic [AW:0] AE_V  = (AW+1)'(AE_TH);

    logic [AW:0] count_q, count_d;
    logic        valid_q, ovf_q, unf_q;
    logic        push_ok, pop_ok;

    assign full         = (count_q == DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_V);
    assign almost_empty = (count_q <= AE_V);

    // Reset gates the grants so the RAM sees an idle command while held.
    assign push_ok = push & ~full & reset;
    assign pop_ok  = pop & ~empty & reset;

    assign rw        = reset ? {pop_ok, push_ok} : RW_IDLE;
    assign ram_data  = data_in;
    assign count     = count_q;
    assign valid_out = valid_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

    fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (push_ok),
        .ptr_o (addrw)
    );

    fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (pop_ok),
        .ptr_o (addrr)
    );

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= pop_ok;
            ovf_q   <= ovf_q | (push & full);
            unf_q   <= unf_q | (pop & empty);
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural RAM and a queue-based
// reference FIFO; read data is checked by a monitor whenever valid_out is high.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    localparam int AW = 3, DW = 4, DEPTH = 8, AF_TH = 6, AE_TH = 2;

    logic          clk = 1'b0, reset = 1'b0, push = 1'b0, pop = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] addrw, addrr;
    logic [1:0]    rw;
    logic          valid_out, full, empty, almost_full, almost_empty;
    logic          overflow_err, underflow_err;
    logic [AW:0]   count;

    fifo_ctrl #(.AW(AW), .DW(DW), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .ram_data(ram_data), .addrw(addrw), .addrr(addrr), .rw(rw),
        .valid_out(valid_out), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: contents as a queue, pointers as plain modulo counters.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    int            wp = 0, rp = 0;
    bit            ovf_m = 0, unf_m = 0, vld_m = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] mon_e;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; entered and left at a falling edge.
    task automatic cycle(bit p, bit q, logic [DW-1:0] d);
        bit pok, qok;
        int n;
        logic [1:0] c_rw;
        logic [AW-1:0] c_aw, c_ar;
        logic [DW-1:0] c_d;
        push = p; pop = q; data_in = d;
        #1;
        n   = mq.size();
        pok = p && (n < DEPTH);
        qok = q && (n > 0);
        chk("rw", 32'(rw), 32'({qok, pok}));
        chk("addrw", 32'(addrw), 32'(wp));
        chk("addrr", 32'(addrr), 32'(rp));
        chk("ram_data", 32'(ram_data), 32'(d));
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AF_TH));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
        chk("overflow_err", 32'(overflow_err), 32'(ovf_m));
        chk("underflow_err", 32'(underflow_err), 32'(unf_m));
        chk("valid_out", 32'(valid_out), 32'(vld_m));
        c_rw = rw; c_aw = addrw; c_ar = addrr; c_d = ram_data;
        @(posedge clk);
        if (c_rw[1]) rdata = mem[c_ar];
        if (c_rw[0]) mem[c_aw] = c_d;
        if (qok) begin exp_q.push_back(mq.pop_front()); rp = (rp + 1) % DEPTH; end
        if (pok) begin mq.push_back(d); wp = (wp + 1) % DEPTH; end
        if (p && n == DEPTH) ovf_m = 1;
        if (q && n == 0) unf_m = 1;
        vld_m = qok;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset && valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rdata: valid_out high with no pop outstanding at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdata", 32'(rdata), 32'(mon_e));
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        push = 1'b1; pop = 1'b1;
        #3;
        chk("rst rw", 32'(rw), 32'(RW_IDLE));
        chk("rst count", 32'(count), 0);
        chk("rst empty", 32'(empty), 1);
        chk("rst full", 32'(full), 0);
        chk("rst almost_empty", 32'(almost_empty), 1);
        chk("rst almost_full", 32'(almost_full), 0);
        chk("rst valid_out", 32'(valid_out), 0);
        chk("rst addrw", 32'(addrw), 0);
        chk("rst addrr", 32'(addrr), 0);
        chk("rst errs", 32'({overflow_err, underflow_err}), 0);
        push = 1'b0; pop = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        repeat (3) cycle(0, 0, '0);
        for (int i = 1; i <= 8; i++) cycle(1, 0, DW'(i));
        cycle(1, 0, 4'h9);
        repeat (9) cycle(0, 1, '0);
        cycle(0, 0, '0);

        for (int i = 0; i < 4; i++) cycle(1, 0, DW'($urandom));
        repeat (10) cycle(1, 1, DW'($urandom));

        while (mq.size() < DEPTH) cycle(1, 0, DW'($urandom));
        cycle(1, 1, DW'($urandom));
        while (mq.size() > 0) cycle(0, 1, '0);
        cycle(1, 1, DW'($urandom));
        cycle(0, 0, '0);

        repeat (250) cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40, DW'($urandom));
        repeat (250) cycle($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 60, DW'($urandom));

        while (mq.size() > 0) cycle(0, 1, '0);
        repeat (2) cycle(0, 0, '0);

        while (mq.size() < 5) cycle(1, 0, DW'($urandom));
        cycle(0, 0, '0);
        push = 1'b0; pop = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        chk("midrst count", 32'(count), 0);
        chk("midrst addrw", 32'(addrw), 0);
        chk("midrst addrr", 32'(addrr), 0);
        chk("midrst errs", 32'({overflow_err, underflow_err}), 0);
        chk("midrst rw", 32'(rw), 32'(RW_IDLE));
        chk("midrst empty", 32'(empty), 1);
        mq.delete(); exp_q.delete();
        wp = 0; rp = 0; ovf_m = 0; unf_m = 0; vld_m = 0;
        @(posedge clk);
        @(negedge clk);
        pop = 1'b0;
        reset = 1'b1;
        cycle(0, 0, '0);
        cycle(1, 0, 4'h5);
        cycle(0, 1, '0);
        repeat (2) cycle(0, 0, '0);

        chk("scoreboard drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
